aes_round_scheduler: RTL and testbench

Sequencing controller for the three-section, round-recirculating AES encryption datapath. It keeps a shadow of the datapath's three pipeline slots and decides, cycle by cycle, when to pop a new plaintext block from the input FIFO into a free slot. It also detects when a slot has completed all rounds and writes it to the output FIFO. When the output FIFO cannot accept a finished block, it freezes the whole ring.

---
 rtl/aes_round_scheduler.sv | 132 +++++++++++++
 tb/tb_aes_round_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/aes_round_scheduler.sv
// Slot-shadow sequencer for the three-register, round-recirculating AES datapath.
// Optional build macro AES_SCHED_PERF_EN adds blk_count/hold_count performance counters.
module aes_round_scheduler #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_empty,
    input  logic       out_full,
    output logic       read_fifo,
    output logic       pipe_hold,
    output logic       out_write,
    output logic [3:0] key_addr,
    output logic [1:0] in_flight,
    output logic       idle
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [15:0] blk_count,
    output logic [15:0] hold_count
`endif
);

    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS);

    function automatic logic [3:0] next_round(input logic [3:0] r);
        return r + 4'd1;
    endfunction

    function automatic logic [1:0] count_valid(input logic va, input logic vb, input logic vc);
        return {1'b0, va} + {1'b0, vb} + {1'b0, vc};
    endfunction

    logic       a_vld_q, a_vld_d;
    logic [3:0] a_rnd_q, a_rnd_d;
    logic       b_vld_q, b_vld_d;
    logic [3:0] b_rnd_q, b_rnd_d;
    logic       c_vld_q, c_vld_d;
    logic [3:0] c_rnd_q, c_rnd_d;

    logic done;
    logic free;

    // Slot C sits at the datapath output/select point, so it alone decides retire, hold and refill.
    always_comb begin
        done      = c_vld_q && (c_rnd_q == ROUND_LAST);
        pipe_hold = done && out_full;
        out_write = done && !out_full;
        free      = !c_vld_q || out_write;
        read_fifo = free && enable && !in_empty;
        key_addr  = b_vld_q ? b_rnd_q : 4'd0;
        in_flight = count_valid(a_vld_q, b_vld_q, c_vld_q);
        idle      = (in_flight == 2'd0);
    end

    always_comb begin
        a_vld_d = a_vld_q;
        a_rnd_d = a_rnd_q;
        b_vld_d = b_vld_q;
        b_rnd_d = b_rnd_q;
        c_vld_d = c_vld_q;
        c_rnd_d = c_rnd_q;
        if (!pipe_hold) begin
            if (read_fifo) begin
                a_vld_d = 1'b1;
                a_rnd_d = 4'd0;
            end else if (free) begin
                a_vld_d = 1'b0;
                a_rnd_d = 4'd0;
            end else begin
                a_vld_d = c_vld_q;
                a_rnd_d = c_rnd_q;
            end
            b_vld_d = a_vld_q;
            b_rnd_d = a_rnd_q;
            // A round is counted as complete when the block leaves section B.
            if (b_vld_q) begin
                c_vld_d = 1'b1;
                c_rnd_d = next_round(b_rnd_q);
            end else begin
                c_vld_d = 1'b0;
                c_rnd_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            a_rnd_q <= 4'd0;
            b_vld_q <= 1'b0;
            b_rnd_q <= 4'd0;
            c_vld_q <= 1'b0;
            c_rnd_q <= 4'd0;
        end else begin
            a_vld_q <= a_vld_d;
            a_rnd_q <= a_rnd_d;
            b_vld_q <= b_vld_d;
            b_rnd_q <= b_rnd_d;
            c_vld_q <= c_vld_d;
            c_rnd_q <= c_rnd_d;
        end
    end

`ifdef AES_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] blk_count_q, blk_count_d;
    logic [15:0] hold_count_q, hold_count_d;

    always_comb begin
        blk_count_d  = out_write ? sat_inc(blk_count_q) : blk_count_q;
        hold_count_d = pipe_hold ? sat_inc(hold_count_q) : hold_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_q  <= 16'd0;
            hold_count_q <= 16'd0;
        end else begin
            blk_count_q  <= blk_count_d;
            hold_count_q <= hold_count_d;
        end
    end

    assign blk_count  = blk_count_q;
    assign hold_count = hold_count_q;
`endif

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler (ROUNDS=10); inputs change 1ns after posedge, outputs checked at negedge.
module tb_aes_round_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       in_empty = 1'b1;
    logic       out_full = 1'b0;
    logic       read_fifo;
    logic       pipe_hold;
    logic       out_write;
    logic [3:0] key_addr;
    logic [1:0] in_flight;
    logic       idle;
`ifdef AES_SCHED_PERF_EN
    logic [15:0] blk_count;
    logic [15:0] hold_count;
`endif

    int total = 0;
    int bad = 0;
    int qcnt;

    aes_round_scheduler #(.ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_empty  (in_empty),
        .out_full  (out_full),
        .read_fifo (read_fifo),
        .pipe_hold (pipe_hold),
        .out_write (out_write),
        .key_addr  (key_addr),
        .in_flight (in_flight),
        .idle      (idle)
`ifdef AES_SCHED_PERF_EN
        ,
        .blk_count (blk_count),
        .hold_count(hold_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        rst = 1'b1;
        enable = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        drive_edge();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        drive_edge();
        drive_edge();
        #4;
        chk("rst_read_fifo", -1, read_fifo, 1'b0);
        chk("rst_pipe_hold", -1, pipe_hold, 1'b0);
        chk("rst_out_write", -1, out_write, 1'b0);
        chk("rst_key_addr", -1, key_addr, 4'd0);
        chk("rst_in_flight", -1, in_flight, 2'd0);
        chk("rst_idle", -1, idle, 1'b1);

        // Single block: read at 0, key round 3 at 11, retire at 30, idle at 31
        for (int t = 0; t <= 32; t++) begin
            drive_edge();
            rst = 1'b0;
            enable = 1'b1;
            in_empty = (t != 0);
            out_full = 1'b0;
            #4;
            chk("s1_read_fifo", t, read_fifo, (t == 0));
            chk("s1_out_write", t, out_write, (t == 30));
            chk("s1_pipe_hold", t, pipe_hold, 1'b0);
            chk("s1_in_flight", t, in_flight, (t >= 1 && t <= 30) ? 2'd1 : 2'd0);
            chk("s1_key_addr", t, key_addr,
                (t >= 2 && t <= 29 && (t % 3) == 2) ? 32'((t - 2) / 3) : 32'd0);
            if (t == 11) chk("s1_key_addr_t11", t, key_addr, 4'd3);
            if (t == 31) chk("s1_idle_t31", t, idle, 1'b1);
        end

        // Output FIFO full t=29..34: hold 30..34, reads blocked while held, retire at 35
        for (int t = 0; t <= 36; t++) begin
            drive_edge();
            enable = 1'b1;
            in_empty = !(t == 0 || (t >= 30 && t <= 34));
            out_full = (t >= 29 && t <= 34);
            #4;
            chk("s3_read_fifo", t, read_fifo, (t == 0));
            chk("s3_pipe_hold", t, pipe_hold, (t >= 30 && t <= 34));
            chk("s3_out_write", t, out_write, (t == 35));
            chk("s3_in_flight", t, in_flight, (t >= 1 && t <= 35) ? 2'd1 : 2'd0);
            if (t >= 30 && t <= 34) chk("s3_key_addr_hold", t, key_addr, 4'd0);
            if (t == 36) chk("s3_idle", t, idle, 1'b1);
        end
`ifdef AES_SCHED_PERF_EN
        chk("perf_blk_count", 37, blk_count, 16'd2);
        chk("perf_hold_count", 37, hold_count, 16'd5);
`endif

        // Four queued blocks: reads 0,1,2,30; writes 30,31,32,60
        do_reset();
        qcnt = 4;
        for (int t = 0; t <= 62; t++) begin
            if (t > 0) drive_edge();
            enable = 1'b1;
            in_empty = (qcnt == 0);
            out_full = 1'b0;
            #4;
            chk("s2_read_fifo", t, read_fifo, (t <= 2 || t == 30));
            chk("s2_out_write", t, out_write, (t >= 30 && t <= 32) || t == 60);
            if (t == 15) chk("s2_in_flight_full", t, in_flight, 2'd3);
            if (t == 30) chk("s2_in_flight_swap", t, in_flight, 2'd3);
            if (t == 31) chk("s2_in_flight_refill", t, in_flight, 2'd3);
            if (t == 33) chk("s2_in_flight_one", t, in_flight, 2'd1);
            if (t == 61) chk("s2_idle", t, idle, 1'b1);
            if (read_fifo && qcnt > 0) qcnt--;
        end

        // Enable dropped at t=5 with input non-empty: drain only
        do_reset();
        for (int t = 0; t <= 34; t++) begin
            if (t > 0) drive_edge();
            enable = (t < 5);
            in_empty = 1'b0;
            #4;
            chk("s4_read_fifo", t, read_fifo, (t <= 2));
            chk("s4_out_write", t, out_write, (t >= 30 && t <= 32));
            if (t == 33) chk("s4_idle", t, idle, 1'b1);
        end

        // Reset pulsed mid-flight at t=15 discards all three blocks
        do_reset();
        for (int t = 0; t <= 45; t++) begin
            if (t > 0) drive_edge();
            rst = (t == 15);
            enable = (t < 15);
            in_empty = (t >= 15);
            #4;
            if (t == 15) chk("s5_in_flight_pre", t, in_flight, 2'd3);
            if (t == 16) chk("s5_in_flight_post", t, in_flight, 2'd0);
            if (t == 16) chk("s5_idle_post", t, idle, 1'b1);
            chk("s5_out_write", t, out_write, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
